// File: rtl/adc_capture_ctrl.sv
// Acquisition sequencer: arms on start, decimates the ADC sample stream, finds a
// ch1 level crossing (or a timeout-forced trigger) and writes {ch2,ch1} pairs to a buffer.
module adc_capture_ctrl #(
    parameter int DATA_SIZE    = 16,
    parameter int ADDR_SIZE    = 10,
    parameter int DECIM_SIZE   = 16,
    parameter int TIMEOUT_SIZE = 24
) (
    input  logic                    i_sys_clock,
    input  logic                    i_reset,
    input  logic                    i_init_done,
    input  logic [DATA_SIZE-1:0]    i_data_ch1,
    input  logic [DATA_SIZE-1:0]    i_data_ch2,
    input  logic                    i_start,
    input  logic                    i_abort,
    input  logic [DATA_SIZE-1:0]    i_trig_level,
    input  logic                    i_trig_rising,
    input  logic                    i_auto_trig,
    input  logic [TIMEOUT_SIZE-1:0] i_timeout,
    input  logic [ADDR_SIZE-1:0]    i_num_samples,
    input  logic [DECIM_SIZE-1:0]   i_decim,
    output logic                    o_wr_en,
    output logic [ADDR_SIZE-1:0]    o_wr_addr,
    output logic [2*DATA_SIZE-1:0]  o_wr_data,
    output logic                    o_busy,
    output logic                    o_armed,
    output logic                    o_done,
    output logic                    o_auto_fired
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARM     = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]                    state_q, state_d;
    logic signed [DATA_SIZE-1:0]   level_q, level_d;
    logic                          rising_q, rising_d;
    logic                          auto_q, auto_d;
    logic [TIMEOUT_SIZE-1:0]       timeout_q, timeout_d;
    logic [ADDR_SIZE-1:0]          nsamp_q, nsamp_d;
    logic [DECIM_SIZE-1:0]         decim_q, decim_d;
    logic [DECIM_SIZE-1:0]         decim_cnt_q, decim_cnt_d;
    logic [TIMEOUT_SIZE-1:0]       to_cnt_q, to_cnt_d;
    logic signed [DATA_SIZE-1:0]   prev_ch1_q, prev_ch1_d;
    logic                          prev_valid_q, prev_valid_d;
    logic [ADDR_SIZE-1:0]          idx_q, idx_d;
    logic                          last_q, last_d;
    logic                          wr_en_q, wr_en_d;
    logic [ADDR_SIZE-1:0]          wr_addr_q, wr_addr_d;
    logic [2*DATA_SIZE-1:0]        wr_data_q, wr_data_d;
    logic                          done_q, done_d;
    logic                          auto_fired_q, auto_fired_d;
    logic                          busy_q, armed_q;

    logic                          busy_s, abort_s, tick_s, cross_s, force_s, issue_s;
    logic signed [DATA_SIZE-1:0]   ch1_s;

    assign ch1_s   = $signed(i_data_ch1);
    assign busy_s  = (state_q == S_ARM) || (state_q == S_CAPTURE);
    assign abort_s = busy_s && (i_abort || !i_init_done);
    assign tick_s  = busy_s && (decim_cnt_q == {DECIM_SIZE{1'b0}});
    assign force_s = auto_q && (to_cnt_q >= timeout_q);
    assign cross_s = prev_valid_q &&
                     (rising_q ? ((prev_ch1_q < level_q) && (ch1_s >= level_q))
                               : ((prev_ch1_q > level_q) && (ch1_s <= level_q)));

    // Next-state logic for the sequencer, counters and write port.
    always_comb begin
        state_d      = state_q;
        level_d      = level_q;
        rising_d     = rising_q;
        auto_d       = auto_q;
        timeout_d    = timeout_q;
        nsamp_d      = nsamp_q;
        decim_d      = decim_q;
        decim_cnt_d  = decim_cnt_q;
        to_cnt_d     = to_cnt_q;
        prev_ch1_d   = prev_ch1_q;
        prev_valid_d = prev_valid_q;
        idx_d        = idx_q;
        last_d       = last_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        done_d       = done_q;
        auto_fired_d = auto_fired_q;
        issue_s      = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start && i_init_done) begin
                    state_d      = S_ARM;
                    level_d      = $signed(i_trig_level);
                    rising_d     = i_trig_rising;
                    auto_d       = i_auto_trig;
                    timeout_d    = i_timeout;
                    nsamp_d      = i_num_samples;
                    decim_d      = i_decim;
                    decim_cnt_d  = {DECIM_SIZE{1'b0}};
                    to_cnt_d     = {TIMEOUT_SIZE{1'b0}};
                    prev_valid_d = 1'b0;
                    idx_d        = {ADDR_SIZE{1'b0}};
                    last_d       = 1'b0;
                    done_d       = 1'b0;
                    auto_fired_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_ARM: begin
                if (abort_s) begin
                    state_d = S_IDLE;
                end else begin
                    if (to_cnt_q != {TIMEOUT_SIZE{1'b1}}) begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q;
                    end
                    decim_cnt_d = (decim_cnt_q >= decim_q) ? {DECIM_SIZE{1'b0}} : decim_cnt_q + 1'b1;
                    if (tick_s) begin
                        prev_ch1_d   = ch1_s;
                        prev_valid_d = 1'b1;
                        if (cross_s || force_s) begin
                            state_d      = S_CAPTURE;
                            issue_s      = 1'b1;
                            auto_fired_d = !cross_s;
                        end else begin
                            state_d = S_ARM;
                        end
                    end else begin
                        state_d = S_ARM;
                    end
                end
            end
            S_CAPTURE: begin
                // last_q rises together with the final write, so DONE follows that write.
                if (abort_s) begin
                    state_d = S_IDLE;
                end else if (last_q) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end else begin
                    decim_cnt_d = (decim_cnt_q >= decim_q) ? {DECIM_SIZE{1'b0}} : decim_cnt_q + 1'b1;
                    issue_s     = tick_s;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (issue_s) begin
            wr_en_d   = 1'b1;
            wr_addr_d = idx_q;
            wr_data_d = {i_data_ch2, i_data_ch1};
            idx_d     = idx_q + 1'b1;
            last_d    = (idx_q == nsamp_q);
        end else begin
            wr_en_d = 1'b0;
        end
    end

    // State, configuration and output registers.
    always_ff @(posedge i_sys_clock) begin
        if (i_reset) begin
            state_q      <= S_IDLE;
            level_q      <= {DATA_SIZE{1'b0}};
            rising_q     <= 1'b0;
            auto_q       <= 1'b0;
            timeout_q    <= {TIMEOUT_SIZE{1'b0}};
            nsamp_q      <= {ADDR_SIZE{1'b0}};
            decim_q      <= {DECIM_SIZE{1'b0}};
            decim_cnt_q  <= {DECIM_SIZE{1'b0}};
            to_cnt_q     <= {TIMEOUT_SIZE{1'b0}};
            prev_ch1_q   <= {DATA_SIZE{1'b0}};
            prev_valid_q <= 1'b0;
            idx_q        <= {ADDR_SIZE{1'b0}};
            last_q       <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= {ADDR_SIZE{1'b0}};
            wr_data_q    <= {(2*DATA_SIZE){1'b0}};
            done_q       <= 1'b0;
            auto_fired_q <= 1'b0;
            busy_q       <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            level_q      <= level_d;
            rising_q     <= rising_d;
            auto_q       <= auto_d;
            timeout_q    <= timeout_d;
            nsamp_q      <= nsamp_d;
            decim_q      <= decim_d;
            decim_cnt_q  <= decim_cnt_d;
            to_cnt_q     <= to_cnt_d;
            prev_ch1_q   <= prev_ch1_d;
            prev_valid_q <= prev_valid_d;
            idx_q        <= idx_d;
            last_q       <= last_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            done_q       <= done_d;
            auto_fired_q <= auto_fired_d;
            busy_q       <= (state_d == S_ARM) || (state_d == S_CAPTURE);
            armed_q      <= (state_d == S_ARM);
        end
    end

    assign o_wr_en      = wr_en_q;
    assign o_wr_addr    = wr_addr_q;
    assign o_wr_data    = wr_data_q;
    assign o_busy       = busy_q;
    assign o_armed      = armed_q;
    assign o_done       = done_q;
    assign o_auto_fired = auto_fired_q;

endmodule
